data_mem_arbiter: RTL and testbench



---
 rtl/data_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Two-requester front end for the single-port, write-first data_mem.
// Port 0 (core LSU) and port 1 (DMA/debug) share the memory port under
// round-robin priority; port 1 may take a bounded exclusive lock. Every
// transfer returns exactly one response, one cycle later, on its own port.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = DATA_WIDTH,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // port 0: core load/store unit
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  input  logic [DATA_BYTES-1:0] i_req0_wen,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_rdata,
  // port 1: DMA / debug master
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  input  logic [DATA_BYTES-1:0] i_req1_wen,
  input  logic                  i_req1_lock,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_rdata,
  // memory port
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [DATA_BYTES-1:0] o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_LOCK1 = 1'b1
  } state_t;

  // Last lock_cnt value before the lock is forcibly released.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  state_t                state_reg;
  logic                  rr_reg;        // contended winner: 0 = port 0, 1 = port 1
  logic [7:0]            lock_cnt_reg;  // cycles spent in ST_LOCK1
  logic                  rsp_pend_reg;  // a transfer happened last cycle
  logic                  rsp_port_reg;  // ... and this port issued it

  logic                  gnt0;
  logic                  gnt1;
  logic                  contended;
  logic                  lock_exit;
  logic [1:0]            rsp_valid_vec;
  logic [DATA_WIDTH-1:0] rsp_rdata_arr [2];

  assign contended = i_req0_valid && i_req1_valid;
  assign lock_exit = !i_req1_lock || (lock_cnt_reg == LOCK_LAST);

  // Grant decision: zero-latency, suppressed entirely while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_reg == ST_LOCK1) begin
        gnt1 = i_req1_valid;
      end else if (contended) begin
        gnt0 = !rr_reg;
        gnt1 = rr_reg;
      end else begin
        gnt0 = i_req0_valid;
        gnt1 = i_req1_valid;
      end
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  // Memory drive: granted port's request, otherwise an all-zero idle read.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wen   = '0;
    if (gnt0) begin
      o_mem_addr  = i_req0_addr;
      o_mem_wdata = i_req0_wdata;
      o_mem_wen   = i_req0_wen;
    end else if (gnt1) begin
      o_mem_addr  = i_req1_addr;
      o_mem_wdata = i_req1_wdata;
      o_mem_wen   = i_req1_wen;
    end
  end

  // Arbitration FSM, priority pointer, lock counter and response tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_ARB;
      rr_reg       <= 1'b0;
      lock_cnt_reg <= '0;
      rsp_pend_reg <= 1'b0;
      rsp_port_reg <= 1'b0;
    end else begin
      rsp_pend_reg <= gnt0 || gnt1;
      rsp_port_reg <= gnt1;
      case (state_reg)
        ST_ARB: begin
          if (contended) begin
            rr_reg <= !rr_reg;
          end
          if (gnt1 && i_req1_lock) begin
            state_reg    <= ST_LOCK1;
            lock_cnt_reg <= '0;
          end
        end
        ST_LOCK1: begin
          lock_cnt_reg <= lock_cnt_reg + 8'd1;
          if (lock_exit) begin
            // Hand priority to the core that has been waiting on the lock.
            state_reg <= ST_ARB;
            rr_reg    <= 1'b0;
          end
        end
        default: state_reg <= ST_ARB;
      endcase
    end
  end

  // Response steering: the memory's read data goes to the tagged port only.
  // A response tagged just before reset is dropped while reset is high.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_valid_vec[gi] = rsp_pend_reg && !rst && (rsp_port_reg == 1'(gi));
      assign rsp_rdata_arr[gi] = rsp_valid_vec[gi] ? i_mem_rdata : '0;
    end
  endgenerate

  assign o_rsp0_valid = rsp_valid_vec[0];
  assign o_rsp1_valid = rsp_valid_vec[1];
  assign o_rsp0_rdata = rsp_rdata_arr[0];
  assign o_rsp1_rdata = rsp_rdata_arr[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
// Self-checking bench: a write-first data_mem stand-in behind the arbiter,
// a reference model of the arbitration rules, a table of cycle vectors,
// hand-written corner sequences and a randomized phase.
module tb_data_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int DB = 8;
  localparam int LM = 4;
  localparam int NW = 16;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DB-1:0] wen;
  } req_t;

  // one table row: inputs {v0,v1,lk}, expected {ready0,ready1}, {rsp0,rsp1}
  typedef struct packed {
    logic v0, v1, lk;
    logic r0, r1;
    logic s0, s1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  req_t q0, q1;
  logic lk;

  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DB-1:0] mem_wen;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BYTES(DB), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(q0.valid), .o_req0_ready(req0_ready),
    .i_req0_addr(q0.addr), .i_req0_wdata(q0.wdata), .i_req0_wen(q0.wen),
    .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata),
    .i_req1_valid(q1.valid), .o_req1_ready(req1_ready),
    .i_req1_addr(q1.addr), .i_req1_wdata(q1.wdata), .i_req1_wen(q1.wen),
    .i_req1_lock(lk),
    .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
    .i_mem_rdata(mem_rdata)
  );

  // data_mem stand-in: single port, write-first, one-cycle read latency
  logic [DW-1:0] mem [NW] = '{default: '0};
  logic [DW-1:0] env_w;

  always_comb begin
    env_w = mem[mem_addr[6:3]];
    for (int b = 0; b < DB; b++)
      if (mem_wen[b]) env_w[b*8 +: 8] = mem_wdata[b*8 +: 8];
  end

  always @(posedge clk) begin
    mem_rdata <= env_w;
    if (|mem_wen) mem[mem_addr[6:3]] <= env_w;
  end

  // reference model state
  logic [DW-1:0] ref_mem [NW];
  int            prio;          // port that wins the next contended cycle
  bit            locked;
  int            lock_cycles;   // cycles already completed under the lock
  bit            pend_v;
  int            pend_port;
  logic [DW-1:0] pend_data;
  bit            last_g0, last_g1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  vec_t tab [27];

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic req_t mk(input logic v, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DB-1:0] w);
    req_t r;
    r.valid = v; r.addr = a; r.wdata = d; r.wen = w;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.valid = ($urandom_range(0, 99) < 70);
    r.addr  = AW'($urandom_range(0, 127));
    r.wdata = {$urandom, $urandom};
    r.wen   = ($urandom_range(0, 1) == 1) ? DB'($urandom) : '0;
    return r;
  endfunction

  // Mid-cycle: predict grants, memory drive and responses from the rules,
  // compare against the DUT, then advance the model by one cycle.
  task automatic eval();
    bit            g0, g1, e_s0, e_s1;
    req_t          r;
    int            idx;
    logic [DW-1:0] w;
    @(negedge clk);
    g0 = 0;
    g1 = 0;
    if (!rst) begin
      if (locked) g1 = q1.valid;
      else if (q0.valid && q1.valid) begin
        g0 = (prio == 0);
        g1 = (prio == 1);
      end else begin
        g0 = q0.valid;
        g1 = q1.valid;
      end
    end
    r    = g0 ? q0 : (g1 ? q1 : '0);
    e_s0 = !rst && pend_v && (pend_port == 0);
    e_s1 = !rst && pend_v && (pend_port == 1);
    chk_b("ready0", req0_ready, g0);
    chk_b("ready1", req1_ready, g1);
    chk_w("mem_addr", mem_addr, r.addr);
    chk_w("mem_wdata", mem_wdata, r.wdata);
    chk_w("mem_wen", 64'(mem_wen), 64'(r.wen));
    chk_b("rsp0_valid", rsp0_valid, e_s0);
    chk_b("rsp1_valid", rsp1_valid, e_s1);
    chk_w("rsp0_rdata", rsp0_rdata, e_s0 ? pend_data : '0);
    chk_w("rsp1_rdata", rsp1_rdata, e_s1 ? pend_data : '0);
    last_g0 = g0;
    last_g1 = g1;
    if (rst) begin
      pend_v = 0; prio = 0; locked = 0; lock_cycles = 0;
    end else begin
      pend_v    = g0 || g1;
      pend_port = g1 ? 1 : 0;
      if (g0 || g1) begin
        idx = int'(r.addr[6:3]);
        w   = ref_mem[idx];
        for (int b = 0; b < DB; b++)
          if (r.wen[b]) w[b*8 +: 8] = r.wdata[b*8 +: 8];
        ref_mem[idx] = w;
        pend_data    = w;
        $display("xfer cyc=%0d port=%0d addr=%0h wen=%0h word=%0h",
                 cyc, pend_port, r.addr, r.wen, w);
      end
      if (locked) begin
        lock_cycles++;
        if (!lk || lock_cycles == LM) begin
          locked = 0;
          prio   = 0;
        end
      end else begin
        if (q0.valid && q1.valid) prio = 1 - prio;
        if (g1 && lk) begin
          locked      = 1;
          lock_cycles = 0;
        end
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // v0 v1 lk _ r0 r1 _ s0 s1, applied from the post-reset state (LOCK_MAX=4)
    tab[0]  = 7'b110_10_00;  tab[1]  = 7'b110_01_10;  tab[2]  = 7'b110_10_01;
    tab[3]  = 7'b110_01_10;  tab[4]  = 7'b010_01_01;  tab[5]  = 7'b110_10_01;
    tab[6]  = 7'b100_10_10;  tab[7]  = 7'b110_01_10;  tab[8]  = 7'b000_00_01;
    tab[9]  = 7'b000_00_00;
    // lock: entry grant plus LOCK_MAX locked cycles, then the core; rr then 1
    tab[10] = 7'b111_10_00;  tab[11] = 7'b111_01_10;  tab[12] = 7'b111_01_01;
    tab[13] = 7'b111_01_01;  tab[14] = 7'b111_01_01;  tab[15] = 7'b111_01_01;
    tab[16] = 7'b111_10_01;  tab[17] = 7'b111_01_10;
    // early release: exit cycle still grants port 1
    tab[18] = 7'b110_01_01;  tab[19] = 7'b110_10_01;  tab[20] = 7'b100_10_10;
    tab[21] = 7'b000_00_10;
    // lock with port 1 idle: core stays blocked until release
    tab[22] = 7'b011_01_00;  tab[23] = 7'b101_00_01;  tab[24] = 7'b100_00_00;
    tab[25] = 7'b100_10_00;  tab[26] = 7'b000_00_10;

    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    prio = 0; locked = 0; lock_cycles = 0; pend_v = 0; pend_port = 0;
    pend_data = '0; last_g0 = 0; last_g1 = 0;

    // reset with both ports requesting: nothing may be granted or written
    rst = 1'b1;
    lk  = 1'b0;
    q0  = mk(1'b1, 64'h8, 64'h55, 8'hFF);
    q1  = mk(1'b1, 64'h10, 64'h66, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      eval();
      chk_b("rst_ready0", req0_ready, 1'b0);
      chk_b("rst_ready1", req1_ready, 1'b0);
      chk_w("rst_mem_wen", 64'(mem_wen), 64'h0);
      chk_w("rst_mem_addr", mem_addr, 64'h0);
      chk_b("rst_rsp0_valid", rsp0_valid, 1'b0);
      chk_w("rst_rsp1_rdata", rsp1_rdata, 64'h0);
      next();
    end
    rst = 1'b0;

    // table-driven arbitration vectors (reads of words 1 and 2)
    for (int i = 0; i < 27; i++) begin
      q0 = mk(tab[i].v0, 64'h8, 64'h0, 8'h00);
      q1 = mk(tab[i].v1, 64'h10, 64'h0, 8'h00);
      lk = tab[i].lk;
      eval();
      chk_b($sformatf("tab%0d_ready0", i), req0_ready, tab[i].r0);
      chk_b($sformatf("tab%0d_ready1", i), req1_ready, tab[i].r1);
      chk_b($sformatf("tab%0d_rsp0", i), rsp0_valid, tab[i].s0);
      chk_b($sformatf("tab%0d_rsp1", i), rsp1_valid, tab[i].s1);
      next();
    end
    lk = 1'b0;

    // preload word 1 = 0xAABB and word 2 = 0xFFFF, then single read, byte write
    q0 = mk(1'b1, 64'h8, 64'hAABB, 8'hFF);  q1 = '0;
    eval(); next();
    q0 = '0;  q1 = mk(1'b1, 64'h10, 64'hFFFF, 8'hFF);
    eval();
    chk_w("wr_rsp0_rdata", rsp0_rdata, 64'hAABB);
    next();
    q0 = mk(1'b1, 64'h8, 64'h0, 8'h00);  q1 = '0;
    eval();
    chk_b("rd_ready0", req0_ready, 1'b1);
    next();
    q0 = '0;  q1 = mk(1'b1, 64'h10, 64'h11, 8'h01);
    eval();
    chk_b("rd_rsp0_valid", rsp0_valid, 1'b1);
    chk_w("rd_rsp0_rdata", rsp0_rdata, 64'hAABB);
    chk_b("rd_rsp1_valid", rsp1_valid, 1'b0);
    next();
    q0 = mk(1'b1, 64'h10, 64'h0, 8'h00);  q1 = '0;
    eval();
    chk_w("bw_rsp1_rdata", rsp1_rdata, 64'hFF11);
    next();
    q0 = '0;
    eval();
    chk_w("bw_rsp0_rdata", rsp0_rdata, 64'hFF11);
    next();

    // reset in the cycle after a grant: response dropped, priority restored
    q0 = mk(1'b1, 64'h8, 64'h0, 8'h00);  q1 = mk(1'b1, 64'h10, 64'h0, 8'h00);
    eval();
    chk_b("pre_rst_ready0", req0_ready, 1'b1);
    next();
    rst = 1'b1;
    q0  = mk(1'b1, 64'h8, 64'h1234, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      eval();
      chk_b("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
      chk_b("mid_rst_ready0", req0_ready, 1'b0);
      chk_b("mid_rst_ready1", req1_ready, 1'b0);
      chk_w("mid_rst_mem_wen", 64'(mem_wen), 64'h0);
      next();
    end
    rst = 1'b0;
    eval();
    chk_b("post_rst_ready0", req0_ready, 1'b1);
    chk_b("post_rst_ready1", req1_ready, 1'b0);
    next();
    q0 = '0;
    eval(); next();

    // idle: memory port parked on a zero-address read
    q1 = '0;
    for (int i = 0; i < 10; i++) begin
      eval();
      chk_w("idle_mem_wen", 64'(mem_wen), 64'h0);
      chk_w("idle_mem_addr", mem_addr, 64'h0);
      next();
    end

    // randomized traffic with occasional lock toggles and resets
    for (int i = 0; i < 600; i++) begin
      if (!q0.valid || last_g0) q0 = rnd_req();
      if (!q1.valid || last_g1) q1 = rnd_req();
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      rst = ($urandom_range(0, 149) == 0);
      eval();
      next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
